pipelined_multiplier_v2: RTL

Fully pipelined, parametrised integer multiplier with a per-operation signed/unsigned mode and a user tag.
- Accepts one operand pair per clock and returns results in issue order, each carrying its tag.
- Uses valid/ready handshakes on both sides, with backpressure from the consumer.
- Intended as the arithmetic engine for datapath blocks that need sustained multiply throughput instead of one operation per four cycles.

---
 rtl/pipelined_multiplier_v2.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipelined_multiplier_v2.sv
// Fully pipelined signed/unsigned integer multiplier with tag passthrough.
// Whole pipeline advances as one unit whenever the output slot can move.
module pipelined_multiplier_v2 #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy,
    output logic [15:0]        op_count
);

    localparam int PW = 2 * WIDTH;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "WIDTH out of range 2..32");
    end
    if (STAGES < 2 || STAGES > 6) begin : g_bad_stages
        $fatal(1, "STAGES out of range 2..6");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
        $fatal(1, "TAG_W out of range 1..16");
    end

    logic              w_adv;
    logic              r_s1_v;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;
    logic              r_s1_sgn;
    logic [TAG_W-1:0]  r_s1_tag;

    logic              r_v [2:STAGES];
    logic [PW-1:0]     r_p [2:STAGES];
    logic [TAG_W-1:0]  r_t [2:STAGES];

    logic [PW-1:0]     w_ea;
    logic [PW-1:0]     w_eb;
    logic [PW-1:0]     w_prod;
    logic [STAGES-1:0] w_vbits;
    logic [15:0]       r_cnt;

    assign w_adv    = !r_v[STAGES] || out_ready;
    assign in_ready = w_adv;

    // Sign extension only when the operation was issued as signed.
    assign w_ea   = {{WIDTH{r_s1_sgn & r_s1_a[WIDTH-1]}}, r_s1_a};
    assign w_eb   = {{WIDTH{r_s1_sgn & r_s1_b[WIDTH-1]}}, r_s1_b};
    assign w_prod = w_ea * w_eb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sgn <= 1'b0;
            r_s1_tag <= '0;
        end else if (w_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_sgn <= in_signed;
                r_s1_tag <= in_tag;
            end
        end
    end

    // Data only moves with a valid op, so outputs hold across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 2; k <= STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_p[k] <= '0;
                r_t[k] <= '0;
            end
        end else if (w_adv) begin
            r_v[2] <= r_s1_v;
            if (r_s1_v) begin
                r_p[2] <= w_prod;
                r_t[2] <= r_s1_tag;
            end
            for (int k = 3; k <= STAGES; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_p[k] <= r_p[k-1];
                    r_t[k] <= r_t[k-1];
                end
            end
        end
    end

    always_comb begin
        w_vbits    = '0;
        w_vbits[0] = r_s1_v;
        for (int k = 2; k <= STAGES; k++) begin
            w_vbits[k-1] = r_v[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_v[STAGES] && out_ready && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign out_valid  = r_v[STAGES];
    assign out_result = r_p[STAGES];
    assign out_tag    = r_t[STAGES];
    assign busy       = |w_vbits;
    assign op_count   = r_cnt;

endmodule
